// File: rtl/pix_stream_pkg.sv
`default_nettype none
// =============================================================================
// pix_stream_pkg : shared types and helpers for pixel-stream pipeline stages
// Rev 1.0
// =============================================================================
package pix_stream_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } unpack_state_e;

  typedef struct packed {
    logic sop;
    logic eol;
    logic eop;
  } marker_t;

  function automatic int calc_ppw(input int word_w, input int pix_w);
    return word_w / pix_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_pos_counter.sv
`default_nettype none
// =============================================================================
// pixel_pos_counter : raster x/y position tracker with frame/line markers
// Rev 1.0
// =============================================================================
module pixel_pos_counter
  import pix_stream_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    advance,
  output marker_t markers
);

  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign markers.sop = (x_q == '0) && (y_q == '0);
  assign markers.eol = (x_q == X_LAST);
  assign markers.eop = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
`default_nettype wire

// File: rtl/pixel_word_unpacker.sv
`default_nettype none
// =============================================================================
// pixel_word_unpacker : serializes wide words into tagged 8-bit pixel stream
// Optional frame counter enabled by `define UNPACKER_FRAME_CNT_EN.  Rev 1.0
// =============================================================================
module pixel_word_unpacker
  import pix_stream_pkg::*;
#(
  parameter int WORD_W = 256,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              sclr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eol,
  output logic              out_eop,
  output logic [15:0]       frame_count
);

  localparam int PPW   = calc_ppw(WORD_W, PIX_W);
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);

  generate
    if ((WORD_W % PIX_W) != 0 || ((IMG_W * IMG_H) % PPW) != 0) begin : g_cfg_bad
      $fatal(1, "pixel_word_unpacker: frame size must be a whole number of words");
    end
  endgenerate

  unpack_state_e     state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              idx_last;
  logic              pix_hs;
  marker_t           pos_mk;

  assign idx_last  = (idx_q == IDX_LAST);
  assign out_valid = (state_q == FULL);
  assign pix_hs    = out_valid & out_ready;
  // Combinational path out_ready -> in_ready enables bubble-free reload.
  assign in_ready  = reset_reset_n &
                     ((state_q == EMPTY) | (out_valid & idx_last & out_ready));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    if (sclr) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (state_q == EMPTY) begin
      if (in_valid) begin
        buf_d   = in_data;
        idx_d   = '0;
        state_d = FULL;
      end
    end else if (pix_hs) begin
      if (idx_last) begin
        idx_d = '0;
        if (in_valid) begin
          buf_d = in_data;
        end else begin
          state_d = EMPTY;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clear   (sclr),
    .advance (pix_hs),
    .markers (pos_mk)
  );

  assign out_pix = out_valid ? buf_q[idx_q*PIX_W +: PIX_W] : '0;
  assign out_sop = out_valid & pos_mk.sop;
  assign out_eol = out_valid & pos_mk.eol;
  assign out_eop = out_valid & pos_mk.eop;

`ifdef UNPACKER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pix_hs & pos_mk.eop) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'h0;
`endif

endmodule
`default_nettype wire
